// File: rtl/clk_div_monitor_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared FSM state encoding and default widths for clk_div_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_WIDTH   = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_COUNT  = 4;

endpackage

`default_nettype wire

// File: rtl/clk_div_monitor_if.sv
// ============================================================================
// Module      : clk_div_monitor_if
// Description : Control/measurement bundle between a driver and clk_div_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clk_div_monitor_if #(
    parameter int CNT_WIDTH = clk_div_pkg::DEF_CNT_WIDTH
) ();

    logic                 meas_en;
    logic                 clk_div_in;
    logic [CNT_WIDTH-1:0] period_out;
    logic [CNT_WIDTH-1:0] high_out;
    logic                 meas_valid;
    logic                 locked;
    logic                 overflow;

    modport master (
        output meas_en, clk_div_in,
        input  period_out, high_out, meas_valid, locked, overflow
    );

    modport slave (
        input  meas_en, clk_div_in,
        output period_out, high_out, meas_valid, locked, overflow
    );

endinterface

`default_nettype wire

// File: rtl/clk_sync_edge.sv
// ============================================================================
// Module      : clk_sync_edge
// Description : Multi-flop synchronizer for an async level plus rise/fall detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_s,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise =  o_s & ~r_s_d;
    assign o_fall = ~o_s &  r_s_d;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// Module      : clk_div_monitor
// Description : Measures period/high time of a divided clock in clk cycles, with lock/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    clk_div_monitor_if.slave bus
);

    localparam int MW = $clog2(LOCK_COUNT) + 1;
    localparam logic [MW-1:0] c_lock_cnt = MW'(LOCK_COUNT);

    state_t               r_state, w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt, r_period, r_high;
    logic [MW-1:0]        r_match, w_match_nxt;
    logic                 r_valid, r_locked, r_overflow, r_high_seen;
    logic                 w_s, w_rise, w_fall, w_cnt_max, w_capture_high;

    clk_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.clk_div_in),
        .o_s    (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_cnt_max      = (r_cnt == '1);
    // Only the first fall after a rise defines the high time.
    assign w_capture_high = w_fall & ~w_s & ~r_high_seen;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_match_nxt  = MW'(1);
        if (r_cnt == r_period)
            w_match_nxt = (r_match == '1) ? r_match : r_match + 1'b1;
        if (!bus.meas_en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_ARM;
                ST_ARM:     if (w_rise) w_next_state = ST_MEASURE;
                ST_MEASURE: if (!w_rise && w_cnt_max) w_next_state = ST_ARM;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_match     <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_overflow  <= 1'b0;
            r_high_seen <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!bus.meas_en) begin
                r_cnt       <= '0;
                r_match     <= '0;
                r_locked    <= 1'b0;
                r_high_seen <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_overflow <= 1'b0;
                        r_cnt      <= '0;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_cnt       <= CNT_WIDTH'(1);
                            r_high_seen <= 1'b0;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_capture_high) begin
                            r_high      <= r_cnt;
                            r_high_seen <= 1'b1;
                        end
                        // A rise on the saturated count is still a valid period.
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_valid     <= 1'b1;
                            r_cnt       <= CNT_WIDTH'(1);
                            r_high_seen <= 1'b0;
                            r_match     <= w_match_nxt;
                            r_locked    <= (w_match_nxt >= c_lock_cnt);
                        end else if (w_cnt_max) begin
                            r_overflow <= 1'b1;
                            r_locked   <= 1'b0;
                            r_match    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    assign bus.period_out = r_period;
    assign bus.high_out   = r_high;
    assign bus.meas_valid = r_valid;
    assign bus.locked     = r_locked;
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Directed self-checking bench for clk_div_monitor (CNT_WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_monitor;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    // Divided-clock generator state; new ratios take effect at a phase wrap.
    bit gen_en = 1'b0;
    int div_n  = 2, div_h = 1;
    int pend_n = 2, pend_h = 1;
    int ph     = 0;

    clk_div_monitor_if #(.CNT_WIDTH(CW)) bus ();

    clk_div_monitor #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.clk_div_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_en) begin
                bus.clk_div_in = 1'b0;
                ph = div_n - 1;
            end else begin
                if (ph + 1 >= div_n) begin
                    ph    = 0;
                    div_n = pend_n;
                    div_h = pend_h;
                end else begin
                    ph++;
                end
                bus.clk_div_in = (ph < div_h);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (bus.meas_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL wait_valid: got no meas_valid expected pulse within 64 cycles");
        end
    endtask

    task automatic skip_valids(input int n);
        bit ok;
        for (int i = 0; i < n; i++) wait_valid(ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.meas_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_period", int'(bus.period_out), 0);
        chk("reset_high",   int'(bus.high_out),   0);
        chk("reset_valid",  int'(bus.meas_valid), 0);
        chk("reset_locked", int'(bus.locked),     0);
        chk("reset_ovf",    int'(bus.overflow),   0);
        rst = 1'b0;
    endtask

    task automatic test_div2();
        bit ok;
        pend_n = 2; pend_h = 1;
        gen_en = 1'b1;
        bus.meas_en = 1'b1;
        skip_valids(3);
        chk("div2_locked_at3", int'(bus.locked), 0);
        wait_valid(ok);
        chk("div2_period", int'(bus.period_out), 2);
        chk("div2_high",   int'(bus.high_out),   1);
        chk("div2_locked", int'(bus.locked),     1);
        @(negedge clk);
        chk("div2_valid_pulse_width", int'(bus.meas_valid), 0);
    endtask

    task automatic test_div6_div7();
        bit ok;
        pend_n = 6; pend_h = 3;
        skip_valids(3);
        wait_valid(ok);
        chk("div6_period", int'(bus.period_out), 6);
        chk("div6_high",   int'(bus.high_out),   3);
        pend_n = 7; pend_h = 3;
        skip_valids(6);
        chk("div7_period", int'(bus.period_out), 7);
        chk("div7_high",   int'(bus.high_out),   3);
        chk("div7_locked", int'(bus.locked),     1);
    endtask

    task automatic test_switch();
        bit ok;
        pend_n = 4; pend_h = 2;
        skip_valids(6);
        chk("div4_period", int'(bus.period_out), 4);
        chk("div4_locked", int'(bus.locked),     1);
        pend_n = 8; pend_h = 4;
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            if (bus.period_out != CW'(4)) break;
        end
        chk("switch_first_period", int'(bus.period_out), 8);
        chk("switch_unlock",       int'(bus.locked),     0);
        skip_valids(2);
        chk("switch_locked_at3", int'(bus.locked), 0);
        wait_valid(ok);
        chk("switch_relock", int'(bus.locked),   1);
        chk("div8_high",     int'(bus.high_out), 4);
    endtask

    task automatic test_overflow();
        bit ok;
        int n;
        wait_valid(ok);
        gen_en = 1'b0;
        n = 0;
        while (!bus.overflow && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_latency", n, 15);
        chk("ovf_flag",    int'(bus.overflow), 1);
        chk("ovf_unlock",  int'(bus.locked),   0);
        chk("ovf_period_hold", int'(bus.period_out), 8);
    endtask

    task automatic test_disable();
        int seen;
        pend_n = 6; pend_h = 3;
        gen_en = 1'b1;
        skip_valids(5);
        chk("dis_locked_before", int'(bus.locked), 1);
        repeat (2) @(negedge clk);
        bus.meas_en = 1'b0;
        @(negedge clk);
        chk("dis_unlock", int'(bus.locked),     0);
        chk("dis_valid",  int'(bus.meas_valid), 0);
        chk("dis_ovf_sticky", int'(bus.overflow), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.meas_valid) seen++;
        end
        chk("dis_no_valid", seen, 0);
        chk("dis_period_hold", int'(bus.period_out), 6);
        bus.meas_en = 1'b1;
        @(negedge clk);
        chk("reenable_ovf_clear", int'(bus.overflow), 0);
    endtask

    task automatic test_rst_mid();
        bit ok;
        skip_valids(6);
        chk("rst_locked_before", int'(bus.locked), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_period", int'(bus.period_out), 0);
        chk("rst_mid_high",   int'(bus.high_out),   0);
        chk("rst_mid_valid",  int'(bus.meas_valid), 0);
        chk("rst_mid_locked", int'(bus.locked),     0);
        chk("rst_mid_ovf",    int'(bus.overflow),   0);
        rst = 1'b0;
        skip_valids(1);
        wait_valid(ok);
        chk("rst_restart_period", int'(bus.period_out), 6);
        chk("rst_restart_high",   int'(bus.high_out),   3);
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div6_div7();
        test_switch();
        test_overflow();
        test_disable();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
